// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file wordline controller.
//   clr_state_e : clear-sweep FSM states
//   REG_ADDR_W / REG_NUM : default address width and register count
//   onehot_dec  : range-checked one-hot decode, zero for out-of-range addresses
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned REG_NUM    = 16;

  // Widest decode the helper supports; callers slice down to their NUM_WL.
  localparam int unsigned MAX_WL     = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  // One-hot decode of addr into num_wl lines; never wraps an out-of-range index.
  function automatic logic [MAX_WL-1:0] onehot_dec(input logic [31:0]   addr,
                                                   input logic          en,
                                                   input int unsigned   num_wl);
    logic [MAX_WL-1:0] dec;
    dec = '0;
    if (en && (addr < num_wl) && (addr < MAX_WL)) begin
      dec[addr[7:0]] = 1'b1;
    end
    return dec;
  endfunction

endpackage

// File: rtl/wl_decoder.sv
// Combinational ADDR_W -> NUM_WL one-hot decoder with enable and range check.
//   addr_i : address to decode
//   en_i   : decode enable; output is zero when low
//   wl_o   : one-hot wordlines, zero for out-of-range addresses
module wl_decoder
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned NUM_WL = REG_NUM
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              en_i,
  output logic [NUM_WL-1:0] wl_o
);

  assign wl_o = NUM_WL'(onehot_dec(32'(addr_i), en_i, NUM_WL));

endmodule

// File: rtl/regfile_wordline_ctrl.sv
// Registered wordline controller for the register file.
//   clk, rst_n  : clock and asynchronous active-low reset
//   rd_addr_i   : NUM_RD packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_en_i     : per-port read enables
//   rd_wl_o     : registered one-hot read wordlines, port i at [i*NUM_WL +: NUM_WL]
//   rd_bypass_o : registered; read address matched an accepted write
//   wr_addr_i, wr_en_i : write request
//   wr_wl_o     : registered one-hot write wordline (also driven by the clear sweep)
//   wr_stall_o  : combinational; writes are dropped while high
//   clr_req_i   : clear-sweep request, sampled in IDLE
//   clr_busy_o  : sweep in progress
//   clr_done_o  : one-cycle pulse when the sweep completes
module regfile_wordline_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter int unsigned NUM_WL   = REG_NUM,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
  input  logic [NUM_RD-1:0]          rd_en_i,
  output logic [NUM_RD*NUM_WL-1:0]   rd_wl_o,
  output logic [NUM_RD-1:0]          rd_bypass_o,
  input  logic [ADDR_W-1:0]          wr_addr_i,
  input  logic                       wr_en_i,
  output logic [NUM_WL-1:0]          wr_wl_o,
  output logic                       wr_stall_o,
  input  logic                       clr_req_i,
  output logic                       clr_busy_o,
  output logic                       clr_done_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WL - 1);

  clr_state_e                  state_q;
  logic [ADDR_W-1:0]           cnt_q;
  logic [NUM_RD*NUM_WL-1:0]    rd_wl_q;
  logic [NUM_RD-1:0]           rd_bypass_q;
  logic [NUM_WL-1:0]           wr_wl_q;
  logic                        clr_busy_q;
  logic                        clr_done_q;

  logic [NUM_RD*NUM_WL-1:0]    rd_wl_d;
  logic [NUM_RD-1:0]           rd_bypass_d;
  logic [NUM_WL-1:0]           wr_dec_d;
  logic [NUM_WL-1:0]           sweep_wl_d;
  logic                        stall_c;
  logic                        wr_zero_c;
  logic                        wr_acc_c;

  // Writes are blocked for the whole sweep including its DONE cycle.
  assign stall_c   = (state_q != IDLE);
  assign wr_zero_c = ZERO_REG && (wr_addr_i == '0);

  // Write decode; range check lives in the decoder, so any set bit means accepted.
  wl_decoder #(
    .ADDR_W (ADDR_W),
    .NUM_WL (NUM_WL)
  ) u_wr_dec (
    .addr_i (wr_addr_i),
    .en_i   (wr_en_i & ~stall_c & ~wr_zero_c),
    .wl_o   (wr_dec_d)
  );

  assign wr_acc_c = |wr_dec_d;

  // Per-port read decode and same-cycle write-match detection.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    wl_decoder #(
      .ADDR_W (ADDR_W),
      .NUM_WL (NUM_WL)
    ) u_rd_dec (
      .addr_i (rd_addr_i[i*ADDR_W +: ADDR_W]),
      .en_i   (rd_en_i[i]),
      .wl_o   (rd_wl_d[i*NUM_WL +: NUM_WL])
    );

    assign rd_bypass_d[i] = rd_en_i[i] & wr_acc_c &
                            (rd_addr_i[i*ADDR_W +: ADDR_W] == wr_addr_i);
  end

  // Sweep wordline; register 0 is skipped when it is hardwired.
  assign sweep_wl_d = NUM_WL'(onehot_dec(32'(cnt_q),
                                         !(ZERO_REG && (cnt_q == '0)),
                                         NUM_WL));

  // Clear-sweep FSM, counter and all output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_wl_q     <= '0;
      rd_bypass_q <= '0;
      wr_wl_q     <= '0;
      clr_busy_q  <= 1'b0;
      clr_done_q  <= 1'b0;
    end else begin
      rd_wl_q     <= rd_wl_d;
      rd_bypass_q <= rd_bypass_d;
      clr_done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          wr_wl_q <= wr_dec_d;
          if (clr_req_i) begin
            state_q    <= SWEEP;
            cnt_q      <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        SWEEP: begin
          wr_wl_q <= sweep_wl_d;
          if (cnt_q == LAST_IDX) begin
            // Counter parks at zero rather than stepping past the last wordline.
            state_q    <= DONE;
            cnt_q      <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b1;
          end else begin
            cnt_q <= ADDR_W'(cnt_q + 1'b1);
          end
        end
        DONE: begin
          wr_wl_q <= '0;
          state_q <= IDLE;
        end
        default: begin
          wr_wl_q    <= '0;
          state_q    <= IDLE;
          cnt_q      <= '0;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rd_wl_o     = rd_wl_q;
  assign rd_bypass_o = rd_bypass_q;
  assign wr_wl_o     = wr_wl_q;
  assign wr_stall_o  = stall_c;
  assign clr_busy_o  = clr_busy_q;
  assign clr_done_o  = clr_done_q;

endmodule

// File: tb/tb_regfile_wordline_ctrl.sv
// Bench for regfile_wordline_ctrl: a 16-register/2-port instance checked every
// cycle against a behavioural model, and a 12-register/3-port instance checked
// with directed literal expectations.
module tb_regfile_wordline_ctrl;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_errs;

  // Instance A: ADDR_W=4, NUM_WL=16, NUM_RD=2, ZERO_REG=1
  logic [7:0]  a_rd_addr;
  logic [1:0]  a_rd_en;
  logic [31:0] a_rd_wl;
  logic [1:0]  a_byp;
  logic [3:0]  a_wr_addr;
  logic        a_wr_en;
  logic [15:0] a_wr_wl;
  logic        a_stall;
  logic        a_clr_req;
  logic        a_busy;
  logic        a_done;

  // Instance B: ADDR_W=4, NUM_WL=12, NUM_RD=3, ZERO_REG=1
  logic [11:0] b_rd_addr;
  logic [2:0]  b_rd_en;
  logic [35:0] b_rd_wl;
  logic [2:0]  b_byp;
  logic [3:0]  b_wr_addr;
  logic        b_wr_en;
  logic [11:0] b_wr_wl;
  logic        b_stall;
  logic        b_clr_req;
  logic        b_busy;
  logic        b_done;

  regfile_wordline_ctrl #(
    .ADDR_W(4), .NUM_WL(16), .NUM_RD(2), .ZERO_REG(1'b1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_i(a_rd_addr), .rd_en_i(a_rd_en), .rd_wl_o(a_rd_wl), .rd_bypass_o(a_byp),
    .wr_addr_i(a_wr_addr), .wr_en_i(a_wr_en), .wr_wl_o(a_wr_wl), .wr_stall_o(a_stall),
    .clr_req_i(a_clr_req), .clr_busy_o(a_busy), .clr_done_o(a_done)
  );

  regfile_wordline_ctrl #(
    .ADDR_W(4), .NUM_WL(12), .NUM_RD(3), .ZERO_REG(1'b1)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_i(b_rd_addr), .rd_en_i(b_rd_en), .rd_wl_o(b_rd_wl), .rd_bypass_o(b_byp),
    .wr_addr_i(b_wr_addr), .wr_en_i(b_wr_en), .wr_wl_o(b_wr_wl), .wr_stall_o(b_stall),
    .clr_req_i(b_clr_req), .clr_busy_o(b_busy), .clr_done_o(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model of instance A. m_sweep: -1 idle, 0..15 sweeping with the
  // next edge writing register m_sweep, 16 = completion cycle.
  int          m_sweep;
  logic [31:0] e_rd_wl;
  logic [1:0]  e_byp;
  logic [15:0] e_wr_wl;
  logic        e_busy;
  logic        e_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sweep = -1;
      e_rd_wl = '0;
      e_byp   = '0;
      e_wr_wl = '0;
      e_busy  = 1'b0;
      e_done  = 1'b0;
    end else begin
      logic acc;
      acc = a_wr_en && (m_sweep < 0) && (a_wr_addr != 4'd0);
      for (int p = 0; p < 2; p++) begin
        int ra;
        ra = int'(a_rd_addr[p*4 +: 4]);
        e_rd_wl[p*16 +: 16] = a_rd_en[p] ? (16'd1 << ra) : 16'd0;
        e_byp[p] = a_rd_en[p] && acc && (ra == int'(a_wr_addr));
      end
      if (m_sweep < 0) begin
        e_wr_wl = acc ? (16'd1 << a_wr_addr) : 16'd0;
        if (a_clr_req) m_sweep = 0;
      end else if (m_sweep < 16) begin
        e_wr_wl = (m_sweep == 0) ? 16'd0 : (16'd1 << m_sweep);
        m_sweep++;
      end else begin
        e_wr_wl = 16'd0;
        m_sweep = -1;
      end
      e_busy = (m_sweep >= 0) && (m_sweep < 16);
      e_done = (m_sweep == 16);
    end
  end

  // Every-cycle comparison of instance A against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("a_rd_wl",   64'(a_rd_wl), 64'(e_rd_wl));
      chk("a_bypass",  64'(a_byp),   64'(e_byp));
      chk("a_wr_wl",   64'(a_wr_wl), 64'(e_wr_wl));
      chk("a_stall",   64'(a_stall), 64'(m_sweep >= 0));
      chk("a_busy",    64'(a_busy),  64'(e_busy));
      chk("a_done",    64'(a_done),  64'(e_done));
    end
  end

  logic [15:0] wl_log   [0:20];
  logic        busy_log [0:20];
  logic        done_log [0:20];
  logic [1:0]  byp_log  [0:20];
  logic        stall_seen;
  int          busy_cnt;
  int          done_cnt;

  initial begin
    n_checks  = 0;
    n_errs    = 0;
    rst_n     = 1'b0;
    a_rd_addr = '0; a_rd_en = '0; a_wr_addr = '0; a_wr_en = 1'b0; a_clr_req = 1'b0;
    b_rd_addr = '0; b_rd_en = '0; b_wr_addr = '0; b_wr_en = 1'b0; b_clr_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Activity, then asynchronous reset mid-cycle.
    a_rd_en = 2'b11; a_rd_addr = 8'h21; a_wr_en = 1'b1; a_wr_addr = 4'h4;
    step();
    chk("pre_reset_wr_wl", 64'(a_wr_wl), 64'h0010);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_rd_wl",  64'(a_rd_wl), 64'h0);
    chk("reset_wr_wl",  64'(a_wr_wl), 64'h0);
    chk("reset_bypass", 64'(a_byp),   64'h0);
    chk("reset_busy",   64'({a_busy, a_done, a_stall}), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Read decode.
    a_wr_en = 1'b0; a_rd_en = 2'b11; a_rd_addr = 8'h3A;
    step();
    chk("read_port0", 64'(a_rd_wl[15:0]),  64'h0400);
    chk("read_port1", 64'(a_rd_wl[31:16]), 64'h0008);

    // Write decode and hardwired register 0.
    a_rd_en = 2'b00; a_wr_en = 1'b1; a_wr_addr = 4'hF;
    step();
    chk("write_f", 64'(a_wr_wl), 64'h8000);
    a_wr_addr = 4'h0;
    step();
    chk("write_zero", 64'(a_wr_wl), 64'h0000);

    // Bypass patterns.
    a_wr_addr = 4'h5; a_rd_en = 2'b11; a_rd_addr = 8'h65;
    step();
    chk("bypass_p0", 64'(a_byp), 64'h1);
    a_wr_addr = 4'h0; a_rd_addr = 8'h00;
    step();
    chk("bypass_zero", 64'(a_byp), 64'h0);
    chk("read_reg0",   64'(a_rd_wl), 64'h0001_0001);
    a_wr_addr = 4'h9; a_rd_addr = 8'h99;
    step();
    chk("bypass_both", 64'(a_byp), 64'h3);
    a_rd_en = 2'b10;
    step();
    chk("bypass_p1_only", 64'(a_byp), 64'h2);

    // Clear sweep with a same-cycle write, a stalled write and a re-request.
    a_rd_en = 2'b00; a_wr_en = 1'b1; a_wr_addr = 4'h2; a_clr_req = 1'b1;
    step();
    a_wr_en = 1'b0; a_clr_req = 1'b0;
    stall_seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      wl_log[k]   = a_wr_wl;
      busy_log[k] = a_busy;
      done_log[k] = a_done;
      byp_log[k]  = a_byp;
      a_wr_en = 1'b0; a_rd_en = 2'b00; a_clr_req = 1'b0;
      if (k == 4) begin
        a_wr_en = 1'b1; a_wr_addr = 4'h7; a_rd_en = 2'b01; a_rd_addr = 8'h07;
        stall_seen = a_stall;
      end
      if (k == 8) a_clr_req = 1'b1;
      step();
    end
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      busy_cnt += int'(busy_log[k]);
      done_cnt += int'(done_log[k]);
    end
    chk("sweep_same_cycle_wr", 64'(wl_log[1]),  64'h0004);
    chk("sweep_reg0_masked",   64'(wl_log[2]),  64'h0000);
    chk("sweep_reg1",          64'(wl_log[3]),  64'h0002);
    chk("sweep_stall",         64'(stall_seen), 64'h1);
    chk("sweep_wr_dropped",    64'(wl_log[5]),  64'h0008);
    chk("sweep_no_bypass",     64'(byp_log[5]), 64'h0);
    chk("sweep_last_wl",       64'(wl_log[17]), 64'h8000);
    chk("sweep_done_pulse",    64'(done_log[17]), 64'h1);
    chk("sweep_exit_wl",       64'(wl_log[18]), 64'h0000);
    chk("sweep_busy_cycles",   64'(busy_cnt),   64'd16);
    chk("sweep_done_count",    64'(done_cnt),   64'd1);

    // Reset during sweep cycle 5 abandons it without a done pulse.
    a_clr_req = 1'b1;
    step();
    a_clr_req = 1'b0;
    repeat (4) step();
    chk("mid_sweep_busy", 64'(a_busy), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy",  64'(a_busy),  64'h0);
    chk("abort_wr_wl", 64'(a_wr_wl), 64'h0);
    chk("abort_stall", 64'(a_stall), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      busy_cnt += int'(a_busy);
      done_cnt += int'(a_done);
    end
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_no_busy", 64'(busy_cnt), 64'd0);

    // Instance B: non-power-of-two wordline count, three ports.
    b_rd_en = 3'b111; b_rd_addr = {4'd0, 4'd11, 4'd13};
    step();
    chk("b_read_oob",   64'(b_rd_wl[11:0]),  64'h000);
    chk("b_read_11",    64'(b_rd_wl[23:12]), 64'h800);
    chk("b_read_0",     64'(b_rd_wl[35:24]), 64'h001);
    b_wr_en = 1'b1; b_wr_addr = 4'd13;
    step();
    chk("b_write_oob",  64'(b_wr_wl), 64'h000);
    chk("b_bypass_oob", 64'(b_byp),   64'h0);
    b_wr_addr = 4'd11;
    step();
    chk("b_write_11",   64'(b_wr_wl), 64'h800);
    chk("b_bypass_11",  64'(b_byp),   64'h2);
    b_wr_en = 1'b0; b_rd_en = 3'b000; b_clr_req = 1'b1;
    step();
    b_clr_req = 1'b0;
    busy_cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      wl_log[k]   = 16'(b_wr_wl);
      busy_log[k] = b_busy;
      done_log[k] = b_done;
      busy_cnt += int'(b_busy);
      step();
    end
    chk("b_sweep_busy_cycles", 64'(busy_cnt),    64'd12);
    chk("b_sweep_reg0_masked", 64'(wl_log[2]),   64'h000);
    chk("b_sweep_reg1",        64'(wl_log[3]),   64'h002);
    chk("b_sweep_last_wl",     64'(wl_log[13]),  64'h800);
    chk("b_sweep_done",        64'(done_log[13]), 64'h1);
    chk("b_sweep_exit_wl",     64'(wl_log[14]),  64'h000);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wordline_ctrl.md
Name: regfile_wordline_ctrl

Overview:
Parametrised, registered wordline controller for the register file. Decodes NUM_RD read addresses and one write address into one-hot wordlines, with one pipeline register stage. Flags same-cycle read/write address matches for bypass. Contains a clear-sweep FSM that walks every write wordline once, used to zero the register file after boot or on a flush.

Parameters:
ADDR_W, 4, register address width
NUM_WL, 16, number of wordlines/registers; legal range 2 to 2**ADDR_W
NUM_RD, 2, number of read ports
ZERO_REG, 1, when 1, register 0 is hardwired: write wordline bit 0 is never asserted and address 0 never flags bypass

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
rd_addr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
rd_en  in  NUM_RD  per-port read enable
rd_wl  out  NUM_RD*NUM_WL  registered one-hot read wordlines; port i occupies bits [i*NUM_WL +: NUM_WL]
rd_bypass  out  NUM_RD  registered; port i read address matched an accepted write address
wr_addr  in  ADDR_W  write address
wr_en  in  1  write enable
wr_wl  out  NUM_WL  registered one-hot write wordline
wr_stall  out  1  combinational; writes are being dropped (sweep active)
clr_req  in  1  start clear sweep, level-sampled in IDLE
clr_busy  out  1  sweep in progress
clr_done  out  1  one-cycle pulse at sweep completion

Behaviour:
- Reset (asynchronous assert, synchronous-edge release): rd_wl=0, rd_bypass=0, wr_wl=0, clr_busy=0, clr_done=0, FSM=IDLE, sweep counter=0. Reset mid-sweep abandons the sweep. No clr_done is produced for an abandoned sweep.
- Latency: 1 cycle. Inputs sampled at edge N drive outputs during cycle N+1.
- Read port i, each edge:
  - rd_wl[i] <= onehot(rd_addr[i]) when rd_en[i]=1 and rd_addr[i] < NUM_WL.
  - Otherwise rd_wl[i] <= 0. An out-of-range address yields all zeros, never a wrapped index.
  - Reads are unaffected by the sweep.
- Write accepted = wr_en & ~wr_stall & (wr_addr < NUM_WL) & ~(ZERO_REG & wr_addr==0).
  - In IDLE: wr_wl <= onehot(wr_addr) if accepted, else 0.
- Bypass: rd_bypass[i] <= rd_en[i] & write accepted & (rd_addr[i]==wr_addr). Several ports may flag in the same cycle.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE: clr_req=1 -> SWEEP, counter<=0. A write presented in the same cycle is still accepted.
  - SWEEP: each edge wr_wl <= onehot(counter), with bit 0 masked when ZERO_REG=1, and counter increments. When counter==NUM_WL-1 -> DONE. Sweep occupies exactly NUM_WL cycles.
  - DONE: one cycle, then -> IDLE; wr_wl <= 0 on exit edge.
  - clr_busy=1 in SWEEP. clr_done=1 in DONE. wr_stall=1 in SWEEP and DONE.
  - clr_req in SWEEP or DONE is ignored; it is not queued. clr_req held high re-enters SWEEP from IDLE on the next cycle.
  - Writes while wr_stall=1 are dropped, with no wordline and no bypass. The upstream stage must hold them.
- Counter width: ADDR_W. It never exceeds NUM_WL-1, so there is no wrap.
- wr_wl and every rd_wl[i] are always zero or one-hot.

Decomposition:
- Shared package regfile_pkg holds:
  - clr_state_e enum (IDLE, SWEEP, DONE)
  - default constants REG_ADDR_W=4, REG_NUM=16
  - function onehot_dec(addr, en), which returns 0 for out-of-range addresses.
- One sub-module is natural: wl_decoder, a parametrised ADDR_W -> NUM_WL combinational one-hot decoder with enable and range check. It is instantiated NUM_RD+1 times via generate.
- The FSM, counter and output registers stay in the top module.

Test Plan:
- Reset, then read: rst_n low mid-activity -> all outputs 0 immediately. Release; rd_en=2'b11, rd_addr={4'h3,4'hA} -> next cycle rd_wl port0=16'h0400, port1=16'h0008.
- Write decode and zero register: wr_en=1, wr_addr=4'hF -> wr_wl=16'h8000. wr_addr=4'h0 with ZERO_REG=1 -> wr_wl=16'h0000.
- Bypass: wr_addr=5, wr_en=1, port0 reads 5, port1 reads 6 -> rd_bypass=2'b01. Repeat with wr_addr=0 and ZERO_REG=1 -> rd_bypass=0.
- Clear sweep: pulse clr_req ->
  - clr_busy high for exactly 16 cycles
  - wr_wl steps 16'h0000 (bit 0 masked), 0x0002 … 0x8000
  - clr_done pulses one cycle, then IDLE.
  - A write to reg 7 during the sweep -> wr_stall=1 and it is dropped.
- Reset mid-sweep and re-request: assert rst_n low at sweep cycle 5 -> state IDLE, clr_done never pulses. clr_req during SWEEP -> no second sweep.
- Non-power-of-2 instance: NUM_WL=12, ADDR_W=4, NUM_RD=3. rd_addr=13 -> rd_wl=0. Sweep lasts 12 cycles and ends at wr_wl=12'h800.
